// File: rtl/median_window_gen_if.sv
// Pixel-stream in / 3x3-window-out bundle for median_window_gen.
// The slave side is the window generator; the master side is whoever
// feeds pixels and consumes windows.
interface median_window_gen_if #(
    parameter int PIX_W = 8
);
    logic               in_valid;
    logic               in_sof;
    logic [PIX_W-1:0]   in_pix;
    logic               out_valid;
    logic [9*PIX_W-1:0] win;
    logic [11:0]        out_row;
    logic [11:0]        out_col;
    logic               frame_done;

    modport master (
        output in_valid, in_sof, in_pix,
        input  out_valid, win, out_row, out_col, frame_done
    );

    modport slave (
        input  in_valid, in_sof, in_pix,
        output out_valid, win, out_row, out_col, frame_done
    );
endinterface

// File: rtl/median_window_gen.sv
// Streaming 3x3 neighbourhood generator feeding the median sort stage.
// Two line buffers hold the previous two rows; a 3x3 column shift register
// assembles the window. Each accepted pixel at (r,c) with r>=2 and c>=2 emits
// the window centred at (r-1,c-1) one cycle later. Slot k = 3*dy+dx sits at
// win[k*PIX_W +: PIX_W], slot 4 is the centre.
module median_window_gen #(
    parameter int IMG_W = 13,
    parameter int IMG_H = 13,
    parameter int PIX_W = 8
) (
    input  logic                clka,
    input  logic                reset,
    median_window_gen_if.slave  bus
);
    localparam int          CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [11:0] COL_LAST = 12'(IMG_W - 1);
    localparam logic [11:0] ROW_LAST = 12'(IMG_H - 1);

    // Line buffers: lb1_r holds row r-1, lb0_r holds row r-2 at the current column.
    logic [PIX_W-1:0]      lb0_r [IMG_W];
    logic [PIX_W-1:0]      lb1_r [IMG_W];

    // Window shift register, same slot layout as the win output.
    logic [8:0][PIX_W-1:0] sr_r;

    logic [11:0]           col_cnt_r;
    logic [11:0]           row_cnt_r;

    logic                  out_valid_r;
    logic                  frame_done_r;
    logic [9*PIX_W-1:0]    win_r;
    logic [11:0]           out_row_r;
    logic [11:0]           out_col_r;

    logic                  accept_s;
    logic [11:0]           col_s;
    logic [11:0]           row_s;
    logic [11:0]           col_nxt_s;
    logic [11:0]           row_nxt_s;
    logic [CW-1:0]         col_idx_s;
    logic [PIX_W-1:0]      top_s;
    logic [PIX_W-1:0]      mid_s;
    logic [8:0][PIX_W-1:0] sr_nxt_s;
    logic                  emit_s;
    logic                  last_s;

    // Effective position of this pixel (start-of-frame forces (0,0)), line-buffer
    // read, next shift-register image and next counter values.
    always_comb begin
        accept_s = bus.in_valid;

        if (bus.in_sof) begin
            col_s = 12'd0;
            row_s = 12'd0;
        end else begin
            col_s = col_cnt_r;
            row_s = row_cnt_r;
        end

        col_idx_s = col_s[CW-1:0];
        top_s     = lb0_r[col_idx_s];
        mid_s     = lb1_r[col_idx_s];

        // Shift every row one column left; new right column is top/mid/incoming.
        sr_nxt_s[0] = sr_r[1];
        sr_nxt_s[1] = sr_r[2];
        sr_nxt_s[2] = top_s;
        sr_nxt_s[3] = sr_r[4];
        sr_nxt_s[4] = sr_r[5];
        sr_nxt_s[5] = mid_s;
        sr_nxt_s[6] = sr_r[7];
        sr_nxt_s[7] = sr_r[8];
        sr_nxt_s[8] = bus.in_pix;

        // Only interior centres are emitted; stale columns across a row wrap are
        // masked by the col >= 2 condition.
        emit_s = accept_s && (row_s >= 12'd2) && (col_s >= 12'd2);
        last_s = (row_s == ROW_LAST) && (col_s == COL_LAST);

        if (col_s == COL_LAST) begin
            col_nxt_s = 12'd0;
            if (row_s == ROW_LAST) begin
                row_nxt_s = 12'd0;
            end else begin
                row_nxt_s = row_s + 12'd1;
            end
        end else begin
            col_nxt_s = col_s + 12'd1;
            row_nxt_s = row_s;
        end
    end

    // Line-buffer update: old row r-1 moves down to the r-2 buffer, the new pixel
    // takes its place; reads above see the pre-write contents.
    always_ff @(posedge clka) begin
        if (accept_s) begin
            lb0_r[col_idx_s] <= mid_s;
            lb1_r[col_idx_s] <= bus.in_pix;
        end
    end

    // Position counters, shift register and registered window outputs.
    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            col_cnt_r    <= 12'd0;
            row_cnt_r    <= 12'd0;
            sr_r         <= '0;
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            win_r        <= '0;
            out_row_r    <= 12'd0;
            out_col_r    <= 12'd0;
        end else begin
            out_valid_r  <= emit_s;
            frame_done_r <= emit_s && last_s;
            if (accept_s) begin
                col_cnt_r <= col_nxt_s;
                row_cnt_r <= row_nxt_s;
                sr_r      <= sr_nxt_s;
            end
            if (emit_s) begin
                win_r     <= sr_nxt_s;
                out_row_r <= row_s - 12'd1;
                out_col_r <= col_s - 12'd1;
            end
        end
    end

    assign bus.out_valid  = out_valid_r;
    assign bus.frame_done = frame_done_r;
    assign bus.win        = win_r;
    assign bus.out_row    = out_row_r;
    assign bus.out_col    = out_col_r;

endmodule

// File: tb/tb_median_window_gen.sv
// Scoreboard bench for median_window_gen: a 5x5 instance and a 13x13 instance.
// A reference model keeps each frame as a 2-D image array and pushes the
// expected window for every qualifying pixel; a monitor pops on out_valid.
module tb_median_window_gen;

    typedef struct {
        logic [71:0] win;
        int          row;
        int          col;
        logic        fd;
    } exp_t;

    logic        clka = 1'b0;
    logic        reset;
    logic        drv_valid;
    logic        drv_sof;
    logic [7:0]  drv_pix;
    int          sel;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          phase    = 0;
    int          win_cnt [2];
    int          fd_cnt  [2];
    logic        last_acc [2];
    exp_t        eq [2][$];
    int          mr [2];
    int          mc [2];
    logic [7:0]  img [2][13][13];

    logic        ov   [2];
    logic        ofd  [2];
    logic [71:0] ow   [2];
    logic [11:0] orow [2];
    logic [11:0] ocol [2];

    always #5 clka = ~clka;

    median_window_gen_if #(.PIX_W(8)) bus_s ();
    median_window_gen_if #(.PIX_W(8)) bus_b ();

    assign bus_s.in_valid = drv_valid && (sel == 0);
    assign bus_s.in_sof   = drv_sof;
    assign bus_s.in_pix   = drv_pix;
    assign bus_b.in_valid = drv_valid && (sel == 1);
    assign bus_b.in_sof   = drv_sof;
    assign bus_b.in_pix   = drv_pix;

    median_window_gen #(.IMG_W(5), .IMG_H(5), .PIX_W(8)) dut_s (
        .clka  (clka),
        .reset (reset),
        .bus   (bus_s)
    );

    median_window_gen #(.IMG_W(13), .IMG_H(13), .PIX_W(8)) dut_b (
        .clka  (clka),
        .reset (reset),
        .bus   (bus_b)
    );

    assign ov[0]   = bus_s.out_valid;
    assign ofd[0]  = bus_s.frame_done;
    assign ow[0]   = bus_s.win;
    assign orow[0] = bus_s.out_row;
    assign ocol[0] = bus_s.out_col;
    assign ov[1]   = bus_b.out_valid;
    assign ofd[1]  = bus_b.frame_done;
    assign ow[1]   = bus_b.win;
    assign orow[1] = bus_b.out_row;
    assign ocol[1] = bus_b.out_col;

    function automatic int gw(input int i);
        return (i == 0) ? 5 : 13;
    endfunction

    function automatic int gh(input int i);
        return (i == 0) ? 5 : 13;
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: place each accepted pixel in the image, emit the 3x3
    // neighbourhood ending at it when it completes an interior window.
    always @(posedge clka or negedge reset) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                mr[i] = 0;
                mc[i] = 0;
                eq[i].delete();
                last_acc[i] = 1'b0;
            end else begin
                last_acc[i] = drv_valid && (sel == i);
                if (drv_valid && (sel == i)) begin
                    if (drv_sof) begin
                        mr[i] = 0;
                        mc[i] = 0;
                    end
                    img[i][mr[i]][mc[i]] = drv_pix;
                    if (mr[i] >= 2 && mc[i] >= 2) begin
                        e.win = '0;
                        for (int dy = 0; dy < 3; dy++)
                            for (int dx = 0; dx < 3; dx++)
                                e.win[(3*dy+dx)*8 +: 8] = img[i][mr[i]-2+dy][mc[i]-2+dx];
                        e.row = mr[i] - 1;
                        e.col = mc[i] - 1;
                        e.fd  = (mr[i] == gh(i) - 1) && (mc[i] == gw(i) - 1);
                        eq[i].push_back(e);
                    end
                    if (mc[i] == gw(i) - 1) begin
                        mc[i] = 0;
                        mr[i] = (mr[i] == gh(i) - 1) ? 0 : mr[i] + 1;
                    end else begin
                        mc[i] = mc[i] + 1;
                    end
                end
            end
        end
    end

    // Monitor: compare every presented window against the scoreboard head.
    always @(negedge clka) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (ov[i]) begin
                win_cnt[i]++;
                if (ofd[i]) fd_cnt[i]++;
                chk("valid_after_accept", {71'd0, last_acc[i]}, 72'd1);
                chk("expect_pending", {71'd0, (eq[i].size() > 0)}, 72'd1);
                if (eq[i].size() > 0) begin
                    e = eq[i].pop_front();
                    chk("win", ow[i], e.win);
                    chk("out_row", {60'd0, orow[i]}, 72'(e.row));
                    chk("out_col", {60'd0, ocol[i]}, 72'(e.col));
                    chk("frame_done", {71'd0, ofd[i]}, {71'd0, e.fd});
                end
                if (i == 0 && phase == 1 && win_cnt[0] == 1) begin
                    chk("first_win", ow[0], 72'h22_21_20_12_11_10_02_01_00);
                    chk("first_row", {60'd0, orow[0]}, 72'd1);
                    chk("first_col", {60'd0, ocol[0]}, 72'd1);
                end
                if (i == 0 && phase == 1 && win_cnt[0] == 9) begin
                    chk("last_centre", {64'd0, ow[0][4*8 +: 8]}, 72'h33);
                    chk("last_slot8", {64'd0, ow[0][8*8 +: 8]}, 72'h44);
                    chk("last_fd", {71'd0, ofd[0]}, 72'd1);
                end
            end else begin
                chk("fd_without_valid", {71'd0, ofd[i]}, 72'd0);
                chk("late_window", 72'(eq[i].size()), 72'd0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clka);
            drv_valid = 1'b0;
            drv_sof   = 1'b0;
        end
    endtask

    task automatic send_frame(input int w, input int off, input int gap,
                              input int npix, input bit ramp);
        for (int k = 0; k < npix; k++) begin
            int r;
            int c;
            r = k / w;
            c = k % w;
            if (gap > 0) idle(int'($urandom_range(gap, 0)));
            @(negedge clka);
            drv_valid = 1'b1;
            drv_sof   = (k == 0);
            drv_pix   = ramp ? 8'(r * w + c) : 8'(16 * r + c + off);
        end
    endtask

    task automatic start_phase(input int p, input int s);
        phase = p;
        sel   = s;
        for (int i = 0; i < 2; i++) begin
            win_cnt[i] = 0;
            fd_cnt[i]  = 0;
        end
    endtask

    task automatic end_phase(input int i, input int n_win, input int n_fd);
        idle(3);
        chk("window_count", 72'(win_cnt[i]), 72'(n_win));
        chk("frame_done_count", 72'(fd_cnt[i]), 72'(n_fd));
        chk("queue_drained", 72'(eq[i].size()), 72'd0);
    endtask

    task automatic chk_zero(input int i);
        chk("rst_out_valid", {71'd0, ov[i]}, 72'd0);
        chk("rst_win", ow[i], 72'd0);
        chk("rst_out_row", {60'd0, orow[i]}, 72'd0);
        chk("rst_out_col", {60'd0, ocol[i]}, 72'd0);
        chk("rst_frame_done", {71'd0, ofd[i]}, 72'd0);
    endtask

    initial begin
        reset     = 1'b1;
        drv_valid = 1'b0;
        drv_sof   = 1'b0;
        drv_pix   = 8'd0;
        sel       = 0;
        start_phase(0, 0);
        #1 reset = 1'b0;
        #2;
        chk_zero(0);
        chk_zero(1);
        repeat (2) @(negedge clka);
        reset = 1'b1;

        // Continuous 5x5 frame, pixel = 16*r+c.
        start_phase(1, 0);
        send_frame(5, 0, 0, 25, 1'b0);
        end_phase(0, 9, 1);

        // Same frame with random gaps.
        start_phase(2, 0);
        send_frame(5, 0, 3, 25, 1'b0);
        end_phase(0, 9, 1);

        // Two frames back-to-back, second offset by 0x80.
        start_phase(3, 0);
        send_frame(5, 0, 0, 25, 1'b0);
        send_frame(5, 8'h80, 0, 25, 1'b0);
        end_phase(0, 18, 2);

        // Frame aborted by start-of-frame at the pixel that would be (3,1).
        start_phase(4, 0);
        send_frame(5, 0, 0, 16, 1'b0);
        send_frame(5, 8'h40, 1, 25, 1'b0);
        end_phase(0, 12, 1);

        // Reset pulsed right after accepting (2,3), then a full frame.
        start_phase(5, 0);
        send_frame(5, 0, 0, 14, 1'b0);
        @(negedge clka);
        drv_valid = 1'b0;
        drv_sof   = 1'b0;
        #2 reset = 1'b0;
        #1 chk_zero(0);
        @(negedge clka);
        reset = 1'b1;
        send_frame(5, 0, 0, 25, 1'b0);
        end_phase(0, 11, 1);

        // Default 13x13 geometry, ramp image.
        start_phase(6, 1);
        send_frame(13, 0, 0, 169, 1'b1);
        end_phase(1, 121, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
